// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side arbitration logic.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int unsigned rr_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the priority pointer.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]             req_i,
    input  logic [rr_idx_w(N)-1:0]   ptr_i,
    output logic [N-1:0]             gnt_o,
    output logic [rr_idx_w(N)-1:0]   idx_o,
    output logic                     any_o
);

    localparam int unsigned IDX_W = rr_idx_w(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    // Rotating a doubled copy puts requester (ptr+k) mod N at bit k, so the
    // search reduces to a fixed lowest-set-bit scan followed by a modular add.
    always_comb begin
        dbl = {req_i, req_i} >> ptr_i;
        rot = dbl[N-1:0];
        off = '0;
        for (int unsigned k = N; k > 0; k--) begin
            if (rot[k-1]) begin
                off = IDX_W'(k - 1);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= (IDX_W+1)'(N)) begin
            sum = sum - (IDX_W+1)'(N);
        end
        idx_o = sum[IDX_W-1:0];
        any_o = |req_i;
        gnt_o = '0;
        for (int unsigned j = 0; j < N; j++) begin
            gnt_o[j] = any_o && (idx_o == IDX_W'(j));
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters: round-robin grant,
// single start pulse per grant, busy tracking and a start-acknowledge watchdog.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned START_TIMEOUT = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*8-1:0]         req_data,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic                         tx_start,
    output logic [7:0]                   tx_data,
    input  logic                         tx_busy,
    output logic [rr_idx_w(NUM_REQ)-1:0] grant_id,
    output logic                         active,
    output logic                         timeout_err
);

    localparam int unsigned IDX_W = rr_idx_w(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(START_TIMEOUT) + 1;

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               start_q, start_d;
    logic [7:0]         data_q, data_d;
    logic [IDX_W-1:0]   gid_q, gid_d;
    logic               active_q, active_d;
    logic               terr_q, terr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            ack_q    <= '0;
            start_q  <= 1'b0;
            data_q   <= '0;
            gid_q    <= '0;
            active_q <= 1'b0;
            terr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            ack_q    <= ack_d;
            start_q  <= start_d;
            data_q   <= data_d;
            gid_q    <= gid_d;
            active_q <= active_d;
            terr_q   <= terr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs are registered, so each is computed one cycle ahead of the
    // state it belongs to (e.g. tx_start is decided while in START).
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        start_d = 1'b0;
        data_d  = data_q;
        gid_d   = gid_q;
        terr_d  = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (arb_any && !tx_busy) begin
                    data_d  = req_data[{arb_idx, 3'b000} +: 8];
                    gid_d   = arb_idx;
                    ack_d   = arb_gnt;
                    ptr_d   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_d = START;
                end
            end
            START: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        active_d = (state_d != IDLE);
    end

    assign req_ack     = ack_q;
    assign tx_start    = start_q;
    assign tx_data     = data_q;
    assign grant_id    = gid_q;
    assign active      = active_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized requesters
// checked against a cycle-level round-robin scoreboard and a UART tx model.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned TMO  = 8;
    localparam int unsigned CPB  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_ack;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic [1:0]        grant_id;
    logic              active;
    logic              timeout_err;

    logic        stub_dead;
    logic        force_busy;
    logic        txm_busy;
    logic [9:0]  frame;
    int unsigned tcyc;
    logic        serial;

    int unsigned n_checks;
    int unsigned n_fail;

    uart_tx_arbiter #(
        .NUM_REQ       (NREQ),
        .START_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // UART transmitter model: 10-bit frame, CPB cycles per bit, busy from the
    // cycle after tx_start. stub_dead makes it ignore starts entirely.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txm_busy <= 1'b0;
            tcyc     <= 0;
            frame    <= '1;
        end else if (txm_busy) begin
            if (tcyc == 10 * CPB - 1) txm_busy <= 1'b0;
            else                      tcyc <= tcyc + 1;
        end else if (tx_start && !stub_dead) begin
            txm_busy <= 1'b1;
            tcyc     <= 0;
            frame    <= {1'b1, tx_data, 1'b0};
        end
    end

    assign serial  = txm_busy ? frame[tcyc / CPB] : 1'b1;
    assign tx_busy = txm_busy | force_busy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int j = (p + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ack"},   32'(req_ack),     0);
        check_eq({tag, "_start"}, 32'(tx_start),    0);
        check_eq({tag, "_data"},  32'(tx_data),     0);
        check_eq({tag, "_gid"},   32'(grant_id),    0);
        check_eq({tag, "_act"},   32'(active),      0);
        check_eq({tag, "_terr"},  32'(timeout_err), 0);
    endtask

    task automatic wait_ack(input string tag, output logic [NREQ-1:0] ackv);
        ackv = '0;
        for (int unsigned k = 0; k < 400; k++) begin
            tick();
            if (req_ack != '0) begin
                ackv = req_ack;
                return;
            end
        end
        check_eq({tag, "_ack_seen"}, 32'(req_ack != '0), 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int unsigned k = 0; k < 400; k++) begin
            tick();
            if (!tx_busy && !active) return;
        end
        check_eq({tag, "_idle"}, 32'(active), 0);
    endtask

    initial begin
        logic [NREQ-1:0] ackv;
        logic [9:0]      rx;
        logic [3:0]      order [5];
        int              mptr;
        bit              free_m, busy_seen, start_pend;
        logic [7:0]      start_byte;
        logic [NREQ-1:0] pv, exp_ack;
        logic [NREQ*8-1:0] pdata;
        logic            pbusy;
        int              eidx;

        n_checks   = 0;
        n_fail     = 0;
        stub_dead  = 1'b0;
        force_busy = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        rst_n      = 1'b0;
        tick();
        check_reset_outputs("rst");
        do_reset();

        // Single request, serial frame check
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        tick();
        check_eq("t1_ack",    32'(req_ack),  4'b0001);
        check_eq("t1_gid",    32'(grant_id), 0);
        check_eq("t1_start0", 32'(tx_start), 0);
        check_eq("t1_active", 32'(active),   1);
        req_valid = '0;
        tick();
        check_eq("t1_start",  32'(tx_start), 1);
        check_eq("t1_data",   32'(tx_data),  8'hA5);
        check_eq("t1_ackoff", 32'(req_ack),  0);
        tick();
        check_eq("t1_once",   32'(tx_start), 0);
        rx = '0;
        for (int s = 0; s < 10 * CPB; s++) begin
            if (s % CPB == 2) rx[s / CPB] = serial;
            tick();
        end
        check_eq("t1_serial", 32'(rx), 10'b1_1010_0101_0);
        check_eq("t1_hold",   32'(tx_data), 8'hA5);
        wait_idle("t1");

        // All four continuously valid: strict rotation
        do_reset();
        req_data  = {8'h43, 8'h32, 8'h21, 8'h10};
        req_valid = 4'b1111;
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int r = 0; r < 5; r++) begin
            wait_ack("t2", ackv);
            check_eq($sformatf("t2_ack%0d", r), 32'(ackv), 32'(order[r]));
            tick();
            check_eq($sformatf("t2_data%0d", r), 32'(tx_data), 32'(req_data[rr_pick(order[r], 0) * 8 +: 8]));
        end
        req_valid = '0;
        wait_idle("t2");

        // Pointer after granting 2, late arrivals
        do_reset();
        req_data  = {8'h53, 8'h52, 8'h51, 8'h50};
        req_valid = 4'b0100;
        wait_ack("t3a", ackv);
        check_eq("t3_g2", 32'(ackv), 4'b0100);
        req_valid = '0;
        repeat (5) tick();
        req_valid = 4'b0010;
        wait_ack("t3b", ackv);
        check_eq("t3_wrap1", 32'(ackv), 4'b0010);
        req_valid = 4'b0100;
        wait_ack("t3c", ackv);
        check_eq("t3_g2b", 32'(ackv), 4'b0100);
        req_valid = '0;
        repeat (5) tick();
        req_valid = 4'b1010;
        wait_ack("t3d", ackv);
        check_eq("t3_g3", 32'(ackv), 4'b1000);
        req_valid = 4'b0010;
        wait_ack("t3e", ackv);
        check_eq("t3_g1", 32'(ackv), 4'b0010);
        req_valid = '0;
        wait_idle("t3");

        // Watchdog: transmitter never acknowledges
        stub_dead = 1'b1;
        req_valid = 4'b0001;
        wait_ack("t4", ackv);
        check_eq("t4_ack", 32'(ackv), 4'b0001);
        req_valid = '0;
        tick();
        check_eq("t4_start", 32'(tx_start), 1);
        for (int c = 0; c < int'(TMO) - 1; c++) begin
            tick();
            check_eq($sformatf("t4_quiet%0d", c), 32'(timeout_err), 0);
        end
        tick();
        check_eq("t4_terr",   32'(timeout_err), 1);
        check_eq("t4_idle",   32'(active),      0);
        stub_dead = 1'b0;
        req_valid = 4'b0010;
        tick();
        check_eq("t4_terr_off", 32'(timeout_err), 0);
        check_eq("t4_regrant",  32'(req_ack),     4'b0010);
        req_valid = '0;
        tick();
        check_eq("t4_restart", 32'(tx_start), 1);
        wait_idle("t4");

        // Foreign busy blocks grants
        force_busy = 1'b1;
        req_valid  = 4'b1000;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_eq($sformatf("t5_noack%0d", c),   32'(req_ack),  0);
            check_eq($sformatf("t5_nostart%0d", c), 32'(tx_start), 0);
        end
        force_busy = 1'b0;
        tick();
        check_eq("t5_ack", 32'(req_ack),  4'b1000);
        check_eq("t5_gid", 32'(grant_id), 3);
        req_valid = '0;
        wait_idle("t5");

        // Asynchronous reset mid-frame
        req_valid = 4'b0010;
        wait_ack("t6", ackv);
        check_eq("t6_ack", 32'(ackv), 4'b0010);
        req_valid = 4'b0110;
        repeat (6) tick();
        check_eq("t6_busy", 32'(tx_busy), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("t6_lowest", 32'(req_ack), 4'b0010);
        req_valid = '0;
        wait_idle("t6");

        // Randomized requesters against the scoreboard
        do_reset();
        mptr       = 0;
        free_m     = 1'b1;
        busy_seen  = 1'b0;
        start_pend = 1'b0;
        start_byte = '0;
        pv         = '0;
        pdata      = req_data;
        pbusy      = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            exp_ack = '0;
            eidx    = -1;
            if (free_m && pv != '0 && !pbusy) begin
                eidx    = rr_pick(pv, mptr);
                exp_ack = NREQ'(1) << eidx;
            end
            if (exp_ack != '0 || req_ack != '0)
                check_eq("rnd_ack", 32'(req_ack), 32'(exp_ack));
            if (start_pend || tx_start) begin
                check_eq("rnd_start", 32'(tx_start), 32'(start_pend));
                if (start_pend) check_eq("rnd_data", 32'(tx_data), 32'(start_byte));
            end
            start_pend = 1'b0;
            if (eidx >= 0) begin
                check_eq("rnd_gid", 32'(grant_id), 32'(eidx));
                start_pend = 1'b1;
                start_byte = pdata[eidx * 8 +: 8];
                mptr       = (eidx + 1) % NREQ;
                free_m     = 1'b0;
                busy_seen  = 1'b0;
            end else if (!free_m) begin
                if (pbusy)          busy_seen = 1'b1;
                else if (busy_seen) free_m    = 1'b1;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_ack[i]) begin
                    req_valid[i] = 1'($urandom_range(1, 0));
                    req_data[i * 8 +: 8] = 8'($urandom);
                end else if (req_valid[i] && $urandom_range(49, 0) == 0) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(7, 0) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i * 8 +: 8] = 8'($urandom);
                end
            end
            pv    = req_valid;
            pdata = req_data;
            pbusy = tx_busy;
        end
        req_valid = '0;
        wait_idle("rnd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
